sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO; next generation of the team's 8x8 queue, generalised in data width and depth. Adds a true full capacity of DEPTH entries, a fill-level output, programmable almost-full/almost-empty flags, synchronous flush, and a read-valid strobe. Single clock domain; sits between producer/consumer datapath stages, e.g. UART/SPI byte buffering.

---
 rtl/sync_fifo_param.sv | 102 ++++++++++
 tb/tb_sync_fifo_param.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised synchronous FIFO with level, almost flags, flush and rd_valid strobe
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   level
`ifdef SYNC_FIFO_ERR_EN
    ,
    output logic                     overflow,
    output logic                     underflow
`endif
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_LVL   = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_LVL   = (ADDR_W+1)'(AE_THRESH);
    localparam logic [ADDR_W:0] LVL_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              rd_acc;
    logic              wr_acc;

    assign empty        = (level == '0);
    assign full         = (level == FULL_LVL);
    assign almost_full  = (level >= AF_LVL);
    assign almost_empty = (level <= AE_LVL);

    // A read frees a slot in the same edge, so a full FIFO still takes a paired write.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    always_ff @(posedge clk) begin
        if (rst && !flush && wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + PTR_ONE;
            end
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - scoreboard bench for sync_fifo_param (DATA_W=8, DEPTH=8, AF=6, AE=1)
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] level;
`ifdef SYNC_FIFO_ERR_EN
    logic       overflow;
    logic       underflow;
`endif

    int total = 0;
    int bad   = 0;
    int max_level;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    sync_fifo_param #(
        .DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .level(level)
`ifdef SYNC_FIFO_ERR_EN
        , .overflow(overflow), .underflow(underflow)
`endif
    );

    // Monitor: every rd_valid pops one expected word.
    always @(negedge clk) begin
        if (rd_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL spurious_rd_valid act_data=%0h exp=no_read", rd_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    bad++;
                    $display("FAIL rd_data act=%0h exp=%0h", rd_data, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic w, input logic [7:0] wd, input logic r,
                        input logic ev, input logic [7:0] ed);
        wr_en   = w;
        wr_data = wd;
        rd_en   = r;
        if (ev) exp_q.push_back(ed);
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        rd_en   = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_empty"}, int'(empty), 1);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_almost_empty"}, int'(almost_empty), 1);
        chk({tag, "_almost_full"}, int'(almost_full), 0);
        chk({tag, "_level"}, int'(level), 0);
        chk({tag, "_rd_data"}, int'(rd_data), 0);
        chk({tag, "_rd_valid"}, int'(rd_valid), 0);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst = 1'b1;
        step(0, 8'h00, 0, 0, 8'h00);
        chk_reset_state("idle");

        // Fill 0x10..0x17, checking flag thresholds at each level.
        for (int i = 0; i < 8; i++) begin
            step(1, 8'h10 + 8'(i), 0, 0, 8'h00);
            chk($sformatf("fill_level%0d", i + 1), int'(level), i + 1);
            chk($sformatf("fill_ae%0d", i + 1), int'(almost_empty), (i + 1 <= 1) ? 1 : 0);
            chk($sformatf("fill_af%0d", i + 1), int'(almost_full), (i + 1 >= 6) ? 1 : 0);
            chk($sformatf("fill_full%0d", i + 1), int'(full), (i + 1 == 8) ? 1 : 0);
        end
        step(1, 8'hFF, 0, 0, 8'h00);
        chk("drop_level", int'(level), 8);
`ifdef SYNC_FIFO_ERR_EN
        chk("overflow_set", int'(overflow), 1);
`endif

        // Read+write while full: oldest returned, level unchanged.
        step(1, 8'hAA, 1, 1, 8'h10);
        chk("rw_full_level", int'(level), 8);
        chk("rw_full_valid", int'(rd_valid), 1);
        for (int i = 1; i < 8; i++) step(0, 8'h00, 1, 1, 8'h10 + 8'(i));
        step(0, 8'h00, 1, 1, 8'hAA);
        chk("drain_empty", int'(empty), 1);
        chk("drain_level", int'(level), 0);

        // Read+write while empty: write only, no bypass.
        step(1, 8'h55, 1, 0, 8'h00);
        chk("rw_empty_level", int'(level), 1);
        chk("rw_empty_valid", int'(rd_valid), 0);
`ifdef SYNC_FIFO_ERR_EN
        chk("underflow_set", int'(underflow), 1);
`endif
        step(0, 8'h00, 1, 1, 8'h55);
        chk("after_55_empty", int'(empty), 1);

        // Streaming across the pointer wrap with 5 entries resident.
        max_level = 0;
        for (int i = 0; i < 5; i++) step(1, 8'(i * 3), 0, 0, 8'h00);
        for (int i = 5; i < 20; i++) begin
            step(1, 8'(i * 3), 1, 1, 8'((i - 5) * 3));
            if (int'(level) > max_level) max_level = int'(level);
        end
        for (int i = 15; i < 20; i++) step(0, 8'h00, 1, 1, 8'(i * 3));
        chk("wrap_max_level", max_level, 5);
        chk("wrap_empty", int'(empty), 1);

        // Flush at level 4 with wr_en/rd_en asserted.
        for (int i = 0; i < 4; i++) step(1, 8'h21 + 8'(i), 0, 0, 8'h00);
        chk("pre_flush_level", int'(level), 4);
        flush = 1'b1;
        step(1, 8'hEE, 1, 0, 8'h00);
        flush = 1'b0;
        chk("flush_level", int'(level), 0);
        chk("flush_empty", int'(empty), 1);
        chk("flush_rd_data", int'(rd_data), 8'h39);
        chk("flush_rd_valid", int'(rd_valid), 0);
`ifdef SYNC_FIFO_ERR_EN
        chk("flush_overflow", int'(overflow), 0);
        chk("flush_underflow", int'(underflow), 0);
`endif

        // Reset mid-stream with a read requested.
        for (int i = 0; i < 3; i++) step(1, 8'h31 + 8'(i), 0, 0, 8'h00);
        chk("pre_rst_level", int'(level), 3);
        rst = 1'b0;
        step(1, 8'h99, 1, 0, 8'h00);
        chk_reset_state("midrst");
        rst = 1'b1;
        step(1, 8'h77, 0, 0, 8'h00);
        step(0, 8'h00, 1, 1, 8'h77);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
